syn_gpu_job_sched: RTL and testbench
====================================

Name: syn_gpu_job_sched

Overview:
Job scheduler in front of the euclid line-draw engine inside the GPU core.
- Accepts draw jobs from NUM_REQ requesters (host register block, pattern generators).
- Arbitrates round-robin and buffers accepted jobs in a small FIFO.
- Issues one job at a time on the master side of syn_gpu_core_job_intf, then waits for completion.
- Reports status back to the register block.

Parameters:
NUM_REQ, 2, number of job requesters (2..4).
FIFO_DEPTH, 4, job FIFO entries; power of 2.
CNT_W, 16, width of the completed-job counter.
TIMEOUT_CYC, 65535, watchdog limit in clocks (used only with the optional feature).

Ports:
clk_ir  in  1  system clock; all logic is rising-edge.
rst_il  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester job valid.
req_job  in  NUM_REQ x gpu_draw_job_t  per-requester job descriptor.
req_ready  out  NUM_REQ  per-requester accept; a job transfers when valid&ready.
euclid_job_start  out  1  single-cycle start pulse to euclid.
euclid_job_data  out  gpu_draw_job_t  job descriptor to euclid.
euclid_busy  in  1  euclid engine busy.
euclid_job_done  in  1  euclid single-cycle job-complete pulse.
sched_busy  out  1  FIFO not empty, or FSM not in IDLE.
fifo_occ  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
job_cnt  out  CNT_W  completed jobs; wraps.
timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst_il low, async), all outputs and state go to:
  - req_ready=0, euclid_job_start=0, euclid_job_data=0, sched_busy=0, fifo_occ=0, job_cnt=0, timeout_err=0.
  - FSM=IDLE, rr_ptr=0, FIFO empty.
- Arbitration is combinational:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[i] = grant[i] & ~fifo_full. At most one ready bit is high.
  - On accept, rr_ptr <= grant_idx+1 (mod NUM_REQ); otherwise rr_ptr holds.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- FIFO:
  - Registered write and read pointers of width $clog2(FIFO_DEPTH)+1; the MSB distinguishes full from empty, and pointers wrap naturally.
  - fifo_full is computed from registered pointers, so a push is refused when full even in a cycle where a pop occurs.
  - Pop of an empty FIFO never occurs.
  - A push and a pop in the same cycle leave occupancy unchanged.
- FSM:
  - IDLE: if FIFO not empty and euclid_busy=0, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): pop the FIFO head into the euclid_job_data register; euclid_job_start=1 on the next edge (registered); go to WAIT_DONE.
  - WAIT_DONE: euclid_job_start=0. On euclid_job_done=1: job_cnt++ (wraps at 2^CNT_W) and go to IDLE.
- Timing and stability:
  - euclid_job_data is stable from the start pulse until the next ISSUE.
  - Latency from accept in cycle N (empty FIFO, idle engine) to euclid_job_start high is cycle N+3. Back-to-back jobs have a minimum gap of 2 cycles between done and the next start.
- euclid_job_done outside WAIT_DONE is ignored.
- Reset mid-job: queued jobs are dropped and the start pulse is aborted. After reset, IDLE waits for euclid_busy=0 before the next issue.
- fifo_occ and sched_busy are registered and reflect state after the current edge.

Optional Feature:
Macro: SYN_GPU_JOB_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYC without euclid_job_done: timeout_err<=1 (sticky until reset), FSM goes to IDLE, job_cnt is not incremented.
- Undefined: no counter; WAIT_DONE waits indefinitely; timeout_err is tied to 0. The port list is identical in both builds.

Decomposition:
- syn_gpu_pkg gains:
  - gpu_job_sched_state_t enum {IDLE, ISSUE, WAIT_DONE}.
  - Default constants for FIFO depth and timeout.
  - gpu_draw_job_t already resides there.
- One sub-module, syn_gpu_job_fifo: a parameterised synchronous FIFO of gpu_draw_job_t with push/pop/full/empty/occ.
- The arbiter and FSM live in syn_gpu_job_sched.

Test Plan:
1. Single job from req0, engine idle → req_ready[0]=1 that cycle; start pulse 3 cycles later with matching data; euclid_job_done after 10 cycles → job_cnt=1, sched_busy=0.
2. req0 and req1 valid continuously with 6 jobs each → accepts alternate 0,1,0,1…; euclid receives jobs in the same order.
3. Engine held busy, 5 pushes attempted → 4 accepted; fifo_occ=4; req_ready=0 while full; drains in order after done pulses.
4. euclid_busy=1 in IDLE with FIFO non-empty → no start until busy drops; start follows 2 cycles later.
5. Assert rst_il low during WAIT_DONE with 3 jobs queued → all outputs reset asynchronously; FIFO empty; no further starts.
6. With SYN_GPU_JOB_SCHED_TIMEOUT_EN and TIMEOUT_CYC=20, withhold done → timeout_err=1 after 20 cycles; next queued job issues; job_cnt unchanged.

Source files
------------

// File: rtl/syn_gpu_pkg.sv
// syn_gpu_pkg: shared GPU core types and defaults.
// Draw-job descriptor, job scheduler state encoding, scheduler defaults.
package syn_gpu_pkg;

  typedef struct packed {
    logic [7:0]  color;
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] x1;
    logic [11:0] y1;
  } gpu_draw_job_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } gpu_job_sched_state_t;

  localparam int JOB_FIFO_DEPTH_DEF = 4;
  localparam int JOB_TIMEOUT_DEF    = 65535;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/syn_gpu_job_fifo.sv
// syn_gpu_job_fifo: synchronous FIFO of gpu_draw_job_t, DEPTH a power of 2.
// Ports: clk_ir, rst_il, push/push_data, pop/pop_data, full, empty, occ.
module syn_gpu_job_fifo
  import syn_gpu_pkg::*;
#(
  parameter int DEPTH = JOB_FIFO_DEPTH_DEF
) (
  input  logic                   clk_ir,
  input  logic                   rst_il,
  input  logic                   push,
  input  gpu_draw_job_t          push_data,
  input  logic                   pop,
  output gpu_draw_job_t          pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int AW = $clog2(DEPTH);

  gpu_draw_job_t mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra MSB separates full (MSBs differ) from empty (equal).
  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign occ      = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_ir) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/syn_gpu_job_sched.sv
// syn_gpu_job_sched: round-robin job arbiter + FIFO + issue FSM for euclid.
// Ports: req_valid/req_job/req_ready in, euclid_job_start/data out,
// euclid_busy/done in, sched_busy/fifo_occ/job_cnt/timeout_err status.
// Optional watchdog: define SYN_GPU_JOB_SCHED_TIMEOUT_EN.
module syn_gpu_job_sched
  import syn_gpu_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int FIFO_DEPTH  = JOB_FIFO_DEPTH_DEF,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = JOB_TIMEOUT_DEF
) (
  input  logic                        clk_ir,
  input  logic                        rst_il,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  gpu_draw_job_t               req_job [NUM_REQ],
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        euclid_job_start,
  output gpu_draw_job_t               euclid_job_data,
  input  logic                        euclid_busy,
  input  logic                        euclid_job_done,
  output logic                        sched_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_occ,
  output logic [CNT_W-1:0]            job_cnt,
  output logic                        timeout_err
);

  localparam int RW = idx_w(NUM_REQ);

  gpu_job_sched_state_t state;
  logic [RW-1:0]        rr_ptr;
  logic [RW-1:0]        grant_idx;
  logic [RW-1:0]        scan_idx;
  logic                 grant_vld;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 wd_hit;
  gpu_draw_job_t        push_data;
  gpu_draw_job_t        fifo_dout;

  // Scan downward so the requester nearest rr_ptr is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = RW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_il && grant_vld && !fifo_full)
      req_ready[grant_idx] = 1'b1;
  end

  assign push      = |(req_valid & req_ready);
  assign push_data = req_job[grant_idx];
  assign pop       = (state == ISSUE);

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il)
      rr_ptr <= '0;
    else if (push)
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ?
                '0 : grant_idx + 1'b1;
  end

  syn_gpu_job_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_ir   (clk_ir),
    .rst_il   (rst_il),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occ      (fifo_occ)
  );

  assign sched_busy = !fifo_empty || (state != IDLE);

`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT_CYC-th cycle spent in WAIT_DONE.
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)
        wd_cnt <= '0;
      else if (state == WAIT_DONE)
        wd_cnt <= wd_cnt + 1'b1;
      if (state == WAIT_DONE && !euclid_job_done && wd_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state            <= IDLE;
      euclid_job_start <= 1'b0;
      euclid_job_data  <= '0;
      job_cnt          <= '0;
    end else begin
      euclid_job_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty && !euclid_busy)
            state <= ISSUE;
        end
        ISSUE: begin
          euclid_job_data  <= fifo_dout;
          euclid_job_start <= 1'b1;
          state            <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (euclid_job_done) begin
            job_cnt <= job_cnt + 1'b1;
            state   <= IDLE;
          end else if (wd_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_gpu_job_sched.sv
// tb_syn_gpu_job_sched: directed bench for syn_gpu_job_sched.
// Accepted jobs queue in a scoreboard, checked at each euclid start.
module tb_syn_gpu_job_sched;
  import syn_gpu_pkg::*;

  localparam int NR = 2;
  localparam int FD = 4;
  localparam int CW = 16;
  localparam int TC = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  gpu_draw_job_t        req_job [NR];
  logic                 start;
  gpu_draw_job_t        data;
  logic                 busy = 1'b0;
  logic                 auto_done = 1'b0;
  logic                 force_done = 1'b0;
  logic                 done;
  logic                 sbusy;
  logic [$clog2(FD):0]  occ;
  logic [CW-1:0]        cnt;
  logic                 terr;

  int            n_chk = 0;
  int            n_fail = 0;
  gpu_draw_job_t sb [$];
  gpu_draw_job_t mon_exp;
  int            acc_log [$];
  int            rem [NR];
  int            cyc = 0;
  int            acc_cyc = 0;
  int            start_cyc = 0;
  int            n_start = 0;
  int            terr_cyc = -1;
  bit            auto_en = 1'b0;
  int            done_dly = 10;

  assign done = auto_done | force_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syn_gpu_job_sched #(
    .NUM_REQ    (NR),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk_ir          (clk),
    .rst_il          (rst_n),
    .req_valid       (req_valid),
    .req_job         (req_job),
    .req_ready       (req_ready),
    .euclid_job_start(start),
    .euclid_job_data (data),
    .euclid_busy     (busy),
    .euclid_job_done (done),
    .sched_busy      (sbusy),
    .fifo_occ        (occ),
    .job_cnt         (cnt),
    .timeout_err     (terr)
  );

  function automatic gpu_draw_job_t new_job(int r);
    gpu_draw_job_t j;
    j.color = 8'(r * 16 + int'($urandom_range(1, 15)));
    j.x0    = 12'($urandom);
    j.y0    = 12'($urandom);
    j.x1    = 12'($urandom);
    j.y1    = 12'($urandom);
    return j;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(int r, int n);
    rem[r]       = n;
    req_job[r]   = new_job(r);
    req_valid[r] = (n > 0);
  endtask

  // One clock: sample at negedge, drive at posedge+1.
  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        sb.push_back(req_job[i]);
        acc_log.push_back(i);
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        rem[i]--;
        req_job[i] = new_job(i);
      end
      req_valid[i] = (rem[i] > 0);
    end
  endtask

  task automatic wait_starts(int n, int lim, string tag);
    int k = 0;
    while (n_start < n && k < lim) begin
      step();
      k++;
    end
    chk(tag, 64'(n_start), 64'(n));
  endtask

  task automatic wait_idle(int lim, string tag);
    int k = 0;
    while (sbusy && k < lim) begin
      step();
      k++;
    end
    chk(tag, 64'(sbusy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (terr && terr_cyc < 0)
      terr_cyc = cyc;
    if (rst_n && start) begin
      n_start++;
      start_cyc = cyc;
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_empty: start with %0d queued, required >0",
               sb.size());
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        n_chk++;
        assert (data === mon_exp) else begin
          n_fail++;
          $error("FAIL start_data: observed %h expected %h",
                 data, mon_exp);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && start && auto_en) begin
        repeat (done_dly) @(posedge clk);
        #1 auto_done = 1'b1;
        @(posedge clk);
        #1 auto_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int base;
    int b_cyc;
    int s_cyc;
    for (int i = 0; i < NR; i++) begin
      rem[i]     = 0;
      req_job[i] = new_job(i);
    end

    // Reset, with a requester already valid.
    req_valid = 2'b01;
    #12;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_busy", 64'(sbusy), 64'(0));
    chk("rst_occ", 64'(occ), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_terr", 64'(terr), 64'(0));
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();

    // Single job, latency and completion.
    auto_en  = 1'b1;
    done_dly = 10;
    load(0, 1);
    #1 chk("t1_ready", 64'(req_ready), 64'(2'b01));
    step();
    wait_starts(1, 10, "t1_start");
    chk("t1_latency", 64'(start_cyc - acc_cyc), 64'(3));
    k = 0;
    while (cnt != 1 && k < 30) begin
      step();
      k++;
    end
    step();
    chk("t1_cnt", 64'(cnt), 64'(1));
    chk("t1_idle", 64'(sbusy), 64'(0));

    // Done pulse while idle is ignored.
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    step();
    chk("idle_done", 64'(cnt), 64'(1));

    // Two requesters, round-robin order.
    done_dly = 3;
    acc_log.delete();
    base = n_start;
    load(0, 6);
    load(1, 6);
    k = 0;
    while ((rem[0] > 0 || rem[1] > 0) && k < 300) begin
      step();
      k++;
    end
    chk("t2_n_acc", 64'(acc_log.size()), 64'(12));
    if (acc_log.size() == 12) begin
      chk("t2_first", 64'(acc_log[0]), 64'(1));
      for (int i = 1; i < 12; i++)
        chk("t2_alt", 64'(acc_log[i] != acc_log[i-1]), 64'(1));
    end
    wait_starts(base + 12, 150, "t2_starts");
    wait_idle(30, "t2_idle");
    chk("t2_cnt", 64'(cnt), 64'(13));

    // Engine busy: FIFO fills, then drains in order.
    busy = 1'b1;
    acc_log.delete();
    base = n_start;
    load(0, 5);
    repeat (8) step();
    chk("t3_acc", 64'(acc_log.size()), 64'(4));
    chk("t3_occ", 64'(occ), 64'(4));
    chk("t3_ready_full", 64'(req_ready), 64'(0));
    chk("t3_no_start", 64'(n_start), 64'(base));
    busy = 1'b0;
    wait_starts(base + 5, 200, "t3_drain");
    chk("t3_acc_all", 64'(acc_log.size()), 64'(5));
    wait_idle(30, "t3_idle");
    chk("t3_cnt", 64'(cnt), 64'(18));

    // Busy in IDLE holds off issue.
    busy = 1'b1;
    base = n_start;
    load(0, 1);
    repeat (5) step();
    chk("t4_held", 64'(n_start), 64'(base));
    chk("t4_sbusy", 64'(sbusy), 64'(1));
    chk("t4_occ", 64'(occ), 64'(1));
    busy  = 1'b0;
    b_cyc = cyc;
    wait_starts(base + 1, 10, "t4_start");
    chk("t4_gap", 64'(start_cyc - b_cyc), 64'(2));
    wait_idle(30, "t4_idle");
    chk("t4_cnt", 64'(cnt), 64'(19));

    // Reset while waiting on a job with 3 queued.
    auto_en = 1'b0;
    base    = n_start;
    load(0, 4);
    k = 0;
    while (!(n_start == base + 1 && occ == 3) && k < 30) begin
      step();
      k++;
    end
    chk("t5_queued", 64'(occ), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", 64'(req_ready), 64'(0));
    chk("t5_start", 64'(start), 64'(0));
    chk("t5_data", 64'(data), 64'(0));
    chk("t5_busy", 64'(sbusy), 64'(0));
    chk("t5_occ", 64'(occ), 64'(0));
    chk("t5_cnt", 64'(cnt), 64'(0));
    chk("t5_terr", 64'(terr), 64'(0));
    sb.delete();
    rem[0]    = 0;
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();
    chk("t5_no_start", 64'(n_start), 64'(base + 1));
    chk("t5_occ_after", 64'(occ), 64'(0));
    chk("t5_busy_after", 64'(sbusy), 64'(0));

`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
    // Withheld done trips the watchdog; next job still issues.
    base     = n_start;
    terr_cyc = -1;
    load(0, 2);
    wait_starts(base + 1, 10, "t6_start");
    s_cyc = start_cyc;
    k = 0;
    while (terr_cyc < 0 && k < 40) begin
      step();
      k++;
    end
    chk("t6_timeout", 64'(terr_cyc - s_cyc), 64'(TC));
    chk("t6_cnt", 64'(cnt), 64'(0));
    wait_starts(base + 2, 10, "t6_next");
    chk("t6_gap", 64'(start_cyc - terr_cyc), 64'(2));
    chk("t6_sticky", 64'(terr), 64'(1));
`else
    // Withheld done: no watchdog, job stays outstanding.
    base = n_start;
    load(0, 1);
    wait_starts(base + 1, 10, "t6_start");
    s_cyc = start_cyc;
    repeat (30) step();
    chk("t6_terr", 64'(terr), 64'(0));
    chk("t6_busy", 64'(sbusy), 64'(1));
    chk("t6_cnt", 64'(cnt), 64'(0));
    chk("t6_one", 64'(n_start - base), 64'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
